// File: rtl/simple_axi_burst_writer.sv
// SimpleAXI write request -> AXI4 INCR bursts, split at MAX_BURST beats and 4 KB boundaries.
// awvalid 2 cycles after accept; W beats pass straight through (no buffering), master stalls on wready.
module simple_axi_burst_writer #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ID_W   = 1,
    parameter int LEN_W      = 16,
    parameter int MAX_BURST  = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      m_wvalid_i,
    output logic                      m_wready_o,
    input  logic [AXI_ADDR_W-1:0]     m_waddr_i,
    input  logic [AXI_DATA_W-1:0]     m_wdata_i,
    input  logic [LEN_W-1:0]          m_wlen_i,
    output logic                      m_wlast_o,
    output logic                      done_o,
    output logic                      error_o,
    output logic [AXI_ID_W-1:0]       axi_awid_o,
    output logic [AXI_ADDR_W-1:0]     axi_awaddr_o,
    output logic [AXI_LEN_W-1:0]      axi_awlen_o,
    output logic [2:0]                axi_awsize_o,
    output logic [1:0]                axi_awburst_o,
    output logic                      axi_awlock_o,
    output logic [3:0]                axi_awcache_o,
    output logic [2:0]                axi_awprot_o,
    output logic [3:0]                axi_awqos_o,
    output logic                      axi_awvalid_o,
    input  logic                      axi_awready_i,
    output logic [AXI_DATA_W-1:0]     axi_wdata_o,
    output logic [AXI_DATA_W/8-1:0]   axi_wstrb_o,
    output logic                      axi_wlast_o,
    output logic                      axi_wvalid_o,
    input  logic                      axi_wready_i,
    input  logic [AXI_ID_W-1:0]       axi_bid_i,
    input  logic [1:0]                axi_bresp_i,
    input  logic                      axi_bvalid_i,
    output logic                      axi_bready_o
);
    localparam int BYTES = AXI_DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_ADDR, S_DATA, S_RESP, S_GAP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [AXI_ADDR_W-1:0] r_addr;
    logic [AXI_ADDR_W-1:0] r_awaddr;
    logic [LEN_W-1:0]      r_rem;
    logic [OFF_W-1:0]      r_tail;
    logic [AXI_LEN_W:0]    r_beats;
    logic [AXI_LEN_W-1:0]  r_cnt;
    logic [AXI_LEN_W-1:0]  r_awlen;
    logic                  r_awvalid;
    logic                  r_bready;
    logic                  r_error;

    logic [LEN_W:0]        w_len_rnd;
    logic [LEN_W-1:0]      w_rem_init;
    logic [12:0]           w_bnd_beats;
    logic [31:0]           w_beats;
    logic                  w_len_zero;
    logic                  w_beat;
    logic                  w_burst_end;
    logic                  w_req_last;
    logic                  w_unused;

    assign w_len_zero  = (m_wlen_i == '0);
    assign w_len_rnd   = {1'b0, m_wlen_i} + (LEN_W+1)'(BYTES - 1);
    assign w_rem_init  = LEN_W'(w_len_rnd >> OFF_W);
    assign w_beat      = (r_state == S_DATA) && m_wvalid_i && axi_wready_i;
    assign w_burst_end = (r_cnt == r_awlen);
    // r_rem is already net of the current burst, so zero here means this burst ends the request
    assign w_req_last  = w_burst_end && (r_rem == '0);
    assign w_unused    = ^{axi_bid_i, m_waddr_i[OFF_W-1:0]};

    always_comb begin
        w_bnd_beats = (13'd4096 - {1'b0, r_addr[11:0]}) >> OFF_W;
        w_beats     = 32'(r_rem);
        if (w_beats > 32'(MAX_BURST)) w_beats = 32'(MAX_BURST);
        if (w_beats > 32'(w_bnd_beats)) w_beats = 32'(w_bnd_beats);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (m_wvalid_i && !w_len_zero) w_next = S_CALC;
            S_CALC: w_next = S_ADDR;
            S_ADDR: if (axi_awready_i) w_next = S_DATA;
            S_DATA: if (w_beat && w_burst_end) w_next = S_RESP;
            S_RESP: if (axi_bvalid_i) w_next = S_GAP;
            S_GAP:  w_next = (r_rem == '0) ? S_IDLE : S_CALC;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        axi_wvalid_o = 1'b0;
        m_wready_o   = 1'b0;
        axi_wdata_o  = '0;
        axi_wlast_o  = 1'b0;
        axi_wstrb_o  = '0;
        m_wlast_o    = 1'b0;
        done_o       = 1'b0;
        case (r_state)
            S_IDLE: done_o = m_wvalid_i && w_len_zero;
            S_DATA: begin
                axi_wvalid_o = m_wvalid_i;
                m_wready_o   = axi_wready_i;
                axi_wdata_o  = m_wdata_i;
                axi_wlast_o  = w_burst_end;
                axi_wstrb_o  = (w_req_last && r_tail != '0) ? ~({BYTES{1'b1}} << r_tail) : '1;
                m_wlast_o    = axi_wready_i && w_req_last;
            end
            S_GAP:  done_o = (r_rem == '0);
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr    <= '0;
            r_awaddr  <= '0;
            r_rem     <= '0;
            r_tail    <= '0;
            r_beats   <= '0;
            r_cnt     <= '0;
            r_awlen   <= '0;
            r_awvalid <= 1'b0;
            r_bready  <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (m_wvalid_i) begin
                    r_error <= 1'b0;
                    r_addr  <= {m_waddr_i[AXI_ADDR_W-1:OFF_W], OFF_W'(0)};
                    r_rem   <= w_rem_init;
                    r_tail  <= m_wlen_i[OFF_W-1:0];
                end
                S_CALC: begin
                    r_awaddr  <= r_addr;
                    r_awlen   <= AXI_LEN_W'(w_beats - 32'd1);
                    r_beats   <= (AXI_LEN_W+1)'(w_beats);
                    r_awvalid <= 1'b1;
                end
                S_ADDR: if (axi_awready_i) begin
                    r_awvalid <= 1'b0;
                    r_cnt     <= '0;
                    r_addr    <= r_addr + (AXI_ADDR_W'(r_beats) << OFF_W);
                    r_rem     <= r_rem - LEN_W'(r_beats);
                end
                S_DATA: if (w_beat) begin
                    if (w_burst_end) r_bready <= 1'b1;
                    else             r_cnt    <= r_cnt + AXI_LEN_W'(1);
                end
                S_RESP: if (axi_bvalid_i) begin
                    r_bready <= 1'b0;
                    r_error  <= r_error | (axi_bresp_i != 2'b00);
                end
                default: ;
            endcase
        end
    end

    assign axi_awid_o    = '0;
    assign axi_awaddr_o  = r_awaddr;
    assign axi_awlen_o   = r_awlen;
    assign axi_awsize_o  = 3'(OFF_W);
    assign axi_awburst_o = 2'b01;
    assign axi_awlock_o  = 1'b0;
    assign axi_awcache_o = 4'b0000;
    assign axi_awprot_o  = 3'b000;
    assign axi_awqos_o   = 4'b0000;
    assign axi_awvalid_o = r_awvalid;
    assign axi_bready_o  = r_bready;
    assign error_o       = r_error;

endmodule
